// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - sequencer issuing multi-step shifts to an 8-bit 3-bit/cycle shifter
//
// Purpose: accepts one shift request (kind/amt/data), loads the operand into the
// shifter, then issues shift steps of up to 3 bits until amt is consumed, and
// returns the result with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock shared with the shifter
//   reset     synchronous active-high reset
//   start     request strobe, sampled only while ready=1
//   kind      00 LSL, 01 LSR, 10 ASR, 11 reserved (error, operand returned unshifted)
//   amt       total shift amount
//   data      operand
//   ready     idle and accepting a request
//   busy      ~ready
//   done      one-cycle pulse, result valid
//   err       one-cycle pulse with done for kind=11
//   result    registered result, held between done pulses
//   sh_op     shifter op: NOP 000, LOAD 001, LSL 010, LSR 011, ASR 100
//   sh_shamt  shifter step amount (0..3)
//   sh_d_in   shifter load data
//   sh_d_out  shifter registered output
module shift_seq8 #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic [AMT_W-1:0] amt,
  input  logic [7:0]       data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       result,
  output logic [2:0]       sh_op,
  output logic [1:0]       sh_shamt,
  output logic [7:0]       sh_d_in,
  input  logic [7:0]       sh_d_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_data;
  logic [1:0]       r_kind;
  logic [AMT_W-1:0] r_rem;
  logic             r_err_flag;
  logic [7:0]       r_result;
  logic             r_done;
  logic             r_err;
  logic [1:0]       w_step;
  logic [AMT_W-1:0] w_rem_next;
  logic             w_accept;

  // Step size is min(rem, 3); the low two bits are exact whenever rem <= 3.
  assign w_step     = (r_rem > AMT_W'(3)) ? 2'd3 : r_rem[1:0];
  assign w_rem_next = r_rem - AMT_W'(w_step);

  // done is registered at the edge that leaves DONE, so the result is valid
  // alongside it; ready is held low for that cycle so it rises one cycle later.
  assign ready    = (r_state == S_IDLE) && !r_done;
  assign busy     = ~ready;
  assign w_accept = ready && start;
  assign done     = r_done;
  assign err      = r_err;
  assign result   = r_result;

  always_comb begin
    w_next   = r_state;
    sh_op    = 3'b000;
    sh_shamt = 2'd0;
    sh_d_in  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        sh_op   = 3'b001;
        sh_d_in = r_data;
        w_next  = (r_rem == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        case (r_kind)
          2'b00:   sh_op = 3'b010;
          2'b01:   sh_op = 3'b011;
          default: sh_op = 3'b100;
        endcase
        sh_shamt = w_step;
        if (w_rem_next == '0) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_data     <= 8'h00;
      r_kind     <= 2'b00;
      r_rem      <= '0;
      r_err_flag <= 1'b0;
      r_result   <= 8'h00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_data <= data;
            r_kind <= kind;
            // Reserved kind: no shift steps, operand is returned with err.
            r_rem      <= (kind == 2'b11) ? '0 : amt;
            r_err_flag <= (kind == 2'b11);
          end
        end
        S_SHIFT: begin
          r_rem <= w_rem_next;
        end
        S_DONE: begin
          r_result <= sh_d_out;
          r_done   <= 1'b1;
          r_err    <= r_err_flag;
        end
        default: ;
      endcase
    end
  end

endmodule
